// File: rtl/speed_regulator.sv
// speed_regulator: cruise-control target tracking with a rate-limited speed demand
module speed_regulator #(
    parameter int WIDTH     = 8,
    parameter int STEP      = 5,
    parameter int RAMP      = 1,
    parameter int MAX_SPEED = 200,
    parameter int MIN_SPEED = 30
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    input  logic [1:0]       cmd,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] current_speed,
    output logic [WIDTH-1:0] target_speed,
    output logic [WIDTH-1:0] speed_cmd,
    output logic             active,
    output logic             busy,
    output logic             G,
    output logic             Eq,
    output logic             L
);
    localparam logic [1:0] OFF  = 2'd0;
    localparam logic [1:0] HOLD = 2'd1;
    localparam logic [1:0] RAMP_ST = 2'd2;
    localparam logic [1:0] C_SET = 2'd0;
    localparam logic [1:0] C_INC = 2'd1;
    localparam logic [1:0] C_DEC = 2'd2;
    localparam logic [1:0] C_CAN = 2'd3;
    localparam logic [WIDTH-1:0] MAX_W  = WIDTH'(MAX_SPEED);
    localparam logic [WIDTH-1:0] MIN_W  = WIDTH'(MIN_SPEED);
    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] RAMP_W = WIDTH'(RAMP);
    localparam logic [WIDTH:0]   MAX_X  = (WIDTH+1)'(MAX_SPEED);
    localparam logic [WIDTH:0]   DEC_FLOOR = (WIDTH+1)'(MIN_SPEED + STEP);

    logic [1:0]       state, state_n;
    logic [WIDTH-1:0] target_n, speed_cmd_n;
    logic [WIDTH-1:0] clamp_val, inc_val, dec_val, diff, ramp_val;
    logic [WIDTH:0]   inc_sum;
    logic             accept, up, near, active_n;

    assign cmd_ready = (state != RAMP_ST) || (cmd == C_CAN);
    assign accept    = cmd_valid && cmd_ready;
    assign active    = (state == HOLD) || (state == RAMP_ST);
    assign busy      = (state == RAMP_ST);
    assign active_n  = (state_n == HOLD) || (state_n == RAMP_ST);

    // Arithmetic for the next target and the next ramp step; sums are widened so nothing wraps
    always_comb begin
        clamp_val = current_speed < MIN_W ? MIN_W : current_speed > MAX_W ? MAX_W : current_speed;
        inc_sum   = {1'b0, target_speed} + {1'b0, STEP_W};
        inc_val   = inc_sum > MAX_X ? MAX_W : inc_sum[WIDTH-1:0];
        dec_val   = {1'b0, target_speed} < DEC_FLOOR ? MIN_W : target_speed - STEP_W;
        up        = target_speed > speed_cmd;
        diff      = up ? target_speed - speed_cmd : speed_cmd - target_speed;
        near      = diff <= RAMP_W;
        ramp_val  = near ? target_speed : up ? speed_cmd + RAMP_W : speed_cmd - RAMP_W;
    end

    // Command handling and ramp progression; in RAMP only CANCEL can be accepted, so it wins over completion
    always_comb begin
        state_n     = state;
        target_n    = target_speed;
        speed_cmd_n = speed_cmd;
        case (state)
            OFF, HOLD: begin
                if (accept) begin
                    case (cmd)
                        C_SET: begin
                            target_n    = clamp_val;
                            speed_cmd_n = current_speed;
                            state_n     = clamp_val != current_speed ? RAMP_ST : HOLD;
                        end
                        C_INC: begin
                            target_n = state == HOLD ? inc_val : target_speed;
                            state_n  = state == HOLD && inc_val != target_speed ? RAMP_ST : state;
                        end
                        C_DEC: begin
                            target_n = state == HOLD ? dec_val : target_speed;
                            state_n  = state == HOLD && dec_val != target_speed ? RAMP_ST : state;
                        end
                        default: state_n = OFF;
                    endcase
                end
            end
            RAMP_ST: begin
                if (accept) begin
                    state_n = OFF;
                end else begin
                    speed_cmd_n = ramp_val;
                    state_n     = near ? HOLD : RAMP_ST;
                end
            end
            default: state_n = OFF;
        endcase
    end

    // State, target and demand registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= OFF;
            target_speed <= '0;
            speed_cmd    <= '0;
        end else begin
            state        <= state_n;
            target_speed <= target_n;
            speed_cmd    <= speed_cmd_n;
        end
    end

    // Registered target-vs-measured compare, forced low whenever cruise is disengaged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            G  <= 1'b0;
            Eq <= 1'b0;
            L  <= 1'b0;
        end else begin
            G  <= active_n && (target_speed > current_speed);
            Eq <= active_n && (target_speed == current_speed);
            L  <= active_n && (target_speed < current_speed);
        end
    end
endmodule

// File: doc/speed_regulator.md
SPEED_REGULATOR -- requirements
Module: speed_regulator

Interface
REQ-001 Parameter WIDTH, default 8: bit width of all speed values.
REQ-002 Parameter STEP, default 5: target increment/decrement per accepted INC/DEC command.
REQ-003 Parameter RAMP, default 1: maximum change of speed_cmd per clock while ramping.
REQ-004 Parameter MAX_SPEED, default 200: upper saturation limit for the target speed, which SHALL be at most 2^WIDTH-1.
REQ-005 Parameter MIN_SPEED, default 30: lower limit of the target speed, which SHALL be at most MAX_SPEED.
REQ-006 Port list, one per line:
- clk, input, 1: sole clock; all state changes on its rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- cmd_valid, input, 1: command present.
- cmd, input, 2: 00 SET, 01 INC, 10 DEC, 11 CANCEL.
- cmd_ready, output, 1: block accepts a command this cycle.
- current_speed, input, WIDTH: measured vehicle speed.
- target_speed, output, WIDTH: registered cruise target.
- speed_cmd, output, WIDTH: ramped speed demand.
- active, output, 1: cruise engaged.
- busy, output, 1: speed_cmd differs from target_speed.
- G / Eq / L, output, 1 each: registered compare of target_speed vs current_speed (greater, equal, less).

Function
REQ-007 FSM states SHALL be OFF, HOLD and RAMP, with a 2-bit state register.
REQ-008 A command SHALL be accepted only on a rising edge where cmd_valid=1 and cmd_ready=1.
REQ-009 cmd_ready SHALL be 1 in OFF and HOLD.
REQ-010 In RAMP, cmd_ready SHALL be 1 only for CANCEL; SET/INC/DEC presented in RAMP SHALL be stalled, not dropped, and cmd_valid is held by the source.
REQ-011 SET, from OFF or HOLD: target_speed <= clamp(current_speed, MIN_SPEED, MAX_SPEED) and speed_cmd <= current_speed.
- Next state is RAMP if the clamped value differs from current_speed, else HOLD.
REQ-012 INC, in HOLD: target_speed <= min(target_speed+STEP, MAX_SPEED), using a WIDTH+1-bit sum with no wrap-around; next state RAMP if the target changed, else HOLD.
REQ-013 DEC, in HOLD: target_speed <= max(target_speed-STEP, MIN_SPEED), with no underflow wrap; next state RAMP if the target changed, else HOLD.
REQ-014 INC or DEC accepted in OFF SHALL be ignored: no state change, though the command is consumed.
REQ-015 CANCEL, in any state: next state OFF; target_speed and speed_cmd hold their values; active <= 0.
REQ-016 RAMP behaviour, each cycle:
- If |target_speed-speed_cmd| <= RAMP, speed_cmd <= target_speed and the next state is HOLD.
- Otherwise speed_cmd moves RAMP toward target_speed.
REQ-017 active SHALL be 1 exactly when the state is HOLD or RAMP.
REQ-018 busy SHALL be 1 exactly when the state is RAMP.
REQ-019 G/Eq/L SHALL be registered with one-cycle latency from target_speed and current_speed.
- They are valid only while active=1 and are all 0 in OFF.
- Exactly one of them is 1 while active.
REQ-020 Latency: target_speed SHALL update on the edge that accepts a command; speed_cmd SHALL reach its target ceil(|delta|/RAMP) cycles after entering RAMP.
REQ-021 Simultaneous CANCEL and ramp completion: CANCEL SHALL win, giving state OFF.
REQ-022 Illegal state encodings SHALL return to OFF on the next clock edge.

Reset
REQ-023 On rst_n=0, the block SHALL immediately, without waiting for a clock edge, set:
- state to OFF
- target_speed and speed_cmd to 0
- active, busy, G, Eq, L to 0
- cmd_ready to 1
REQ-024 Reset asserted mid-RAMP SHALL abandon the ramp; after deassertion the block SHALL remain in OFF until a SET is accepted.

Verification
REQ-025 The bench SHALL cover the following directed scenarios with default parameters:
- current_speed=100, SET -> target_speed=100, speed_cmd=100, HOLD, active=1, Eq=1 one cycle later.
- In HOLD at 100, three INC -> target_speed 115; each INC ramps 5 cycles with busy=1 and cmd_ready=0 for the stalled INC.
- Target 198, INC -> target_speed=200 (saturated); a further INC -> target_speed stays 200, state remains HOLD.
- current_speed=10, SET -> target_speed=30, RAMP 20 cycles; DEC at target 32 -> target_speed 30, not 27.
- CANCEL mid-RAMP at speed_cmd=107 -> next cycle OFF, active=0, busy=0, speed_cmd=107; INC in OFF -> no change.
- rst_n pulsed low asynchronously mid-RAMP -> all outputs 0 and cmd_ready=1 before the next clk edge; then SET succeeds.
